fsm_ctrl: RTL and testbench
===========================

FSM_CTRL -- requirements
Module: fsm_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 0, meaning extra wait cycles per memory-access state; legal range 0..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset: one clock; asynchronous, active-high.
REQ-004 Opcode  input  6  instruction bits [31:26] from instruction register.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  standard multi-cycle datapath strobes/selects.
REQ-006 ALUop  output  2  to ALU control decoder: 00 addu, 01 sub, 10 funct-decoded.
REQ-007 ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-008 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 State  output  4  current state code, for debug.
REQ-010 Illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-011 Done  output  1  one-cycle pulse on last cycle of every instruction.

Function
REQ-012 Moore FSM, 4-bit state: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, EXE=6, RWB=7, BR=8, JMP=9, IEXE=10, IWB=11; other codes go to IF next cycle.
REQ-013 Transitions: IF->ID (after wait); ID by Opcode: 000000->EXE, 100011/101011->MADR, 000100->BR, 000010->JMP, else IF with Illegal=1 in that ID cycle.
REQ-014 MADR->MRD if Opcode=100011, else MWR; MRD->MWB; EXE->RWB; MWB, MWR, RWB, BR, JMP -> IF.
REQ-015 Outputs not listed for a state are 0.
REQ-016 IF: MemRead=1, ALUSrcB=01, ALUop=00, PCSource=00; IRWrite=1, PCWrite=1 on last cycle only.
REQ-017 ID: ALUSrcB=11, ALUop=00. MADR: ALUSrcA=1, ALUSrcB=10, ALUop=00.
REQ-018 MRD: MemRead=1, IorD=1. MWB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-019 MWR: IorD=1 every cycle; MemWrite=1 on last cycle only.
REQ-020 EXE: ALUSrcA=1, ALUSrcB=00, ALUop=10. RWB: RegWrite=1, RegDst=1.
REQ-021 BR: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. JMP: PCWrite=1, PCSource=10.
REQ-022 IF, MRD, MWR each last MEM_WAIT+1 cycles; 4-bit wait counter clears on state entry, state advances when counter equals MEM_WAIT.
REQ-023 Done=1 in final cycle of MWB, MWR, RWB, BR, JMP, IWB; not on illegal-opcode ID.
REQ-024 Cycle counts with MEM_WAIT=W: lw 5+2W, sw 4+2W, R-type 4+W, beq 3+W, j 3+W.
REQ-025 Opcode sampled only in ID and MADR; changes elsewhere ignored.

Reset
REQ-026 rst asserted: state=IF, wait counter=0 immediately; all outputs including State-derived strobes forced 0, State=0.
REQ-027 First rising edge after rst deassertion is IF cycle 0; rst mid-instruction aborts with no further strobes.

Configuration
REQ-028 Macro FSM_CTRL_ADDI_EN defined: ID decodes 001000 -> IEXE (ALUSrcA=1, ALUSrcB=10, ALUop=00) -> IWB (RegWrite=1, RegDst=0, MemtoReg=0, Done=1) -> IF; addi takes 4+W cycles.
REQ-029 Macro undefined: 001000 treated as illegal per REQ-013; codes 10, 11 unreachable and recover to IF.

Verification
REQ-030 MEM_WAIT=0, Opcode=100011 after reset -> States 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4; Done once.
REQ-031 MEM_WAIT=2, Opcode=101011 -> IF 3 cycles (IRWrite on 3rd), MWR 3 cycles, MemWrite high only in 3rd MWR cycle; total 8 cycles.
REQ-032 Opcode=000100 -> ALUop=01, PCWriteCond=1, PCSource=01 in state 8; Opcode=000010 -> PCWrite=1, PCSource=10 in state 9.
REQ-033 Opcode=111111 -> Illegal pulse in ID, next state IF, Done stays 0; with FSM_CTRL_ADDI_EN, Opcode=001000 -> states 0,1,10,11 and no Illegal.
REQ-034 rst pulsed asynchronously mid-MRD -> State=0, MemRead=0 same cycle; after release IF restarts with no MWB.

Source files
------------

// File: rtl/fsm_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
interface fsm_ctrl_if;
    logic [5:0] Opcode;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] ALUop;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] State;
    logic       Illegal;
    logic       Done;

    modport master (
        input  Opcode,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ALUop, ALUSrcB, PCSource, State, Illegal, Done
    );

    modport slave (
        output Opcode,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ALUop, ALUSrcB, PCSource, State, Illegal, Done
    );
endinterface

// File: rtl/fsm_ctrl.sv
// Multi-cycle MIPS-style main controller (Moore FSM with memory wait states).
// Define FSM_CTRL_ADDI_EN to add the addi path through states IEXE/IWB.
module fsm_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    fsm_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXE  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_IEXE = 4'd10,
        S_IWB  = 4'd11
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
`ifdef FSM_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI   = 6'b001000;
`endif

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] wait_r;
    logic [3:0] wait_nxt_s;
    logic       run_r;
    logic       last_s;
    logic       illegal_s;

    logic       pcw_s, pcwc_s, iord_s, mrd_s, mwr_s, m2r_s, irw_s, asa_s, rw_s, rd_s, done_s;
    logic [1:0] aop_s, asb_s, pcs_s;

    // State and wait counter; run_r keeps the FSM parked and silent until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IF;
            wait_r  <= 4'd0;
            run_r   <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (run_r) begin
                state_r <= state_nxt_s;
                wait_r  <= wait_nxt_s;
            end else begin
                state_r <= state_r;
                wait_r  <= wait_r;
            end
        end
    end

    // Memory states stretch to MEM_WAIT+1 cycles; all others last one cycle.
    always_comb begin
        if (state_r == S_IF || state_r == S_MRD || state_r == S_MWR) begin
            last_s = (wait_r == WAIT_LAST);
        end else begin
            last_s = 1'b1;
        end
    end

    // Next-state logic; the opcode is only looked at in ID and MADR.
    always_comb begin
        state_nxt_s = S_IF;
        illegal_s   = 1'b0;
        case (state_r)
            S_IF:   state_nxt_s = last_s ? S_ID : S_IF;
            S_ID: begin
                case (bus.Opcode)
                    OP_RTYPE:     state_nxt_s = S_EXE;
                    OP_LW, OP_SW: state_nxt_s = S_MADR;
                    OP_BEQ:       state_nxt_s = S_BR;
                    OP_J:         state_nxt_s = S_JMP;
`ifdef FSM_CTRL_ADDI_EN
                    OP_ADDI:      state_nxt_s = S_IEXE;
`endif
                    default: begin
                        state_nxt_s = S_IF;
                        illegal_s   = 1'b1;
                    end
                endcase
            end
            S_MADR: state_nxt_s = (bus.Opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:  state_nxt_s = last_s ? S_MWB : S_MRD;
            S_MWR:  state_nxt_s = last_s ? S_IF : S_MWR;
            S_EXE:  state_nxt_s = S_RWB;
`ifdef FSM_CTRL_ADDI_EN
            S_IEXE: state_nxt_s = S_IWB;
`endif
            default: state_nxt_s = S_IF;
        endcase
        if (state_nxt_s == state_r) begin
            wait_nxt_s = wait_r + 4'd1;
        end else begin
            wait_nxt_s = 4'd0;
        end
    end

    // Moore output decode per state.
    always_comb begin
        pcw_s  = 1'b0; pcwc_s = 1'b0; iord_s = 1'b0; mrd_s = 1'b0; mwr_s = 1'b0;
        m2r_s  = 1'b0; irw_s  = 1'b0; asa_s  = 1'b0; rw_s  = 1'b0; rd_s  = 1'b0;
        done_s = 1'b0;
        aop_s  = 2'b00; asb_s = 2'b00; pcs_s = 2'b00;
        case (state_r)
            S_IF: begin
                mrd_s = 1'b1;
                asb_s = 2'b01;
                irw_s = last_s;
                pcw_s = last_s;
            end
            S_ID:   asb_s = 2'b11;
            S_MADR: begin
                asa_s = 1'b1;
                asb_s = 2'b10;
            end
            S_MRD: begin
                mrd_s  = 1'b1;
                iord_s = 1'b1;
            end
            S_MWB: begin
                rw_s   = 1'b1;
                m2r_s  = 1'b1;
                done_s = 1'b1;
            end
            S_MWR: begin
                iord_s = 1'b1;
                mwr_s  = last_s;
                done_s = last_s;
            end
            S_EXE: begin
                asa_s = 1'b1;
                aop_s = 2'b10;
            end
            S_RWB: begin
                rw_s   = 1'b1;
                rd_s   = 1'b1;
                done_s = 1'b1;
            end
            S_BR: begin
                asa_s  = 1'b1;
                aop_s  = 2'b01;
                pcwc_s = 1'b1;
                pcs_s  = 2'b01;
                done_s = 1'b1;
            end
            S_JMP: begin
                pcw_s  = 1'b1;
                pcs_s  = 2'b10;
                done_s = 1'b1;
            end
`ifdef FSM_CTRL_ADDI_EN
            S_IEXE: begin
                asa_s = 1'b1;
                asb_s = 2'b10;
            end
            S_IWB: begin
                rw_s   = 1'b1;
                done_s = 1'b1;
            end
`endif
            default: done_s = 1'b0;
        endcase
    end

    assign bus.PCWrite     = run_r & pcw_s;
    assign bus.PCWriteCond = run_r & pcwc_s;
    assign bus.IorD        = run_r & iord_s;
    assign bus.MemRead     = run_r & mrd_s;
    assign bus.MemWrite    = run_r & mwr_s;
    assign bus.MemtoReg    = run_r & m2r_s;
    assign bus.IRWrite     = run_r & irw_s;
    assign bus.ALUSrcA     = run_r & asa_s;
    assign bus.RegWrite    = run_r & rw_s;
    assign bus.RegDst      = run_r & rd_s;
    assign bus.ALUop       = run_r ? aop_s : 2'b00;
    assign bus.ALUSrcB     = run_r ? asb_s : 2'b00;
    assign bus.PCSource    = run_r ? pcs_s : 2'b00;
    assign bus.State       = run_r ? state_r : 4'd0;
    assign bus.Illegal     = run_r & illegal_s;
    assign bus.Done        = run_r & done_s;
endmodule

// File: tb/tb_fsm_ctrl.sv
// Scoreboard bench for fsm_ctrl: two instances (MEM_WAIT 0 and 2), exercised one after the other.
module tb_fsm_ctrl;
    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
        logic [1:0] aop, asb, pcs;
        logic ill, dn;
    } ov_t;

    typedef struct packed {
        logic hold;
        ov_t  o;
    } ent_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    ent_t plan[$];
    ov_t  exp0[$];
    ov_t  exp1[$];
    ov_t  act0, act1;

    fsm_ctrl_if bus0();
    fsm_ctrl_if bus1();

    fsm_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fsm_ctrl #(.MEM_WAIT(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    assign act0 = {bus0.State, bus0.PCWrite, bus0.PCWriteCond, bus0.IorD, bus0.MemRead, bus0.MemWrite,
                   bus0.MemtoReg, bus0.IRWrite, bus0.ALUSrcA, bus0.RegWrite, bus0.RegDst,
                   bus0.ALUop, bus0.ALUSrcB, bus0.PCSource, bus0.Illegal, bus0.Done};
    assign act1 = {bus1.State, bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                   bus1.MemtoReg, bus1.IRWrite, bus1.ALUSrcA, bus1.RegWrite, bus1.RegDst,
                   bus1.ALUop, bus1.ALUSrcB, bus1.PCSource, bus1.Illegal, bus1.Done};

    task automatic check(input string name, input ov_t a, input ov_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s (W=%0d, t=%0t): got %h (state %0d) expected %h (state %0d)",
                     name, sel ? 2 : 0, $time, a, a.st, e, e.st);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
`ifdef FSM_CTRL_ADDI_EN
        if (op == OP_ADDI) return 1'b1;
`endif
        return (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J);
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] v;
        v = 6'($urandom);
        while (is_legal(v)) v = v + 6'd1;
        return v;
    endfunction

    task automatic add_phase(input logic [3:0] st, input int len, input ov_t body, input ov_t last,
                             input logic hold);
        for (int i = 0; i < len; i++) begin
            ent_t e;
            e.hold = hold;
            e.o    = body;
            if (i == len - 1) e.o = e.o | last;
            e.o.st = st;
            plan.push_back(e);
        end
    endtask

    // Reference model: expand one instruction into its per-cycle expected outputs.
    task automatic build(input logic [5:0] op, input int w);
        ov_t b, l, z;
        z = '0;
        plan.delete();
        b = '0; l = '0; b.mrd = 1'b1; b.asb = 2'b01; l.irw = 1'b1; l.pcw = 1'b1;
        add_phase(4'd0, w + 1, b, l, 1'b0);
        b = '0; b.asb = 2'b11; b.ill = !is_legal(op);
        add_phase(4'd1, 1, b, z, 1'b1);
        if (!is_legal(op)) return;
        case (op)
            OP_LW, OP_SW: begin
                b = '0; b.asa = 1'b1; b.asb = 2'b10;
                add_phase(4'd2, 1, b, z, 1'b1);
                if (op == OP_LW) begin
                    b = '0; b.mrd = 1'b1; b.iord = 1'b1;
                    add_phase(4'd3, w + 1, b, z, 1'b0);
                    b = '0; b.rw = 1'b1; b.m2r = 1'b1; b.dn = 1'b1;
                    add_phase(4'd4, 1, b, z, 1'b0);
                end else begin
                    b = '0; b.iord = 1'b1; l = '0; l.mwr = 1'b1; l.dn = 1'b1;
                    add_phase(4'd5, w + 1, b, l, 1'b0);
                end
            end
            OP_R: begin
                b = '0; b.asa = 1'b1; b.aop = 2'b10;
                add_phase(4'd6, 1, b, z, 1'b0);
                b = '0; b.rw = 1'b1; b.rd = 1'b1; b.dn = 1'b1;
                add_phase(4'd7, 1, b, z, 1'b0);
            end
            OP_BEQ: begin
                b = '0; b.asa = 1'b1; b.aop = 2'b01; b.pcwc = 1'b1; b.pcs = 2'b01; b.dn = 1'b1;
                add_phase(4'd8, 1, b, z, 1'b0);
            end
            OP_J: begin
                b = '0; b.pcw = 1'b1; b.pcs = 2'b10; b.dn = 1'b1;
                add_phase(4'd9, 1, b, z, 1'b0);
            end
            OP_ADDI: begin
                b = '0; b.asa = 1'b1; b.asb = 2'b10;
                add_phase(4'd10, 1, b, z, 1'b0);
                b = '0; b.rw = 1'b1; b.dn = 1'b1;
                add_phase(4'd11, 1, b, z, 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic drive_op(input logic [5:0] v);
        if (sel) bus1.Opcode = v;
        else     bus0.Opcode = v;
    endtask

    // Push up to n cycles of expectations (n<0: whole instruction) and drive those cycles.
    task automatic run_instr(input logic [5:0] op, input int n);
        int cnt;
        build(op, sel ? 2 : 0);
        cnt = (n < 0 || n > plan.size()) ? plan.size() : n;
        for (int i = 0; i < cnt; i++) begin
            if (sel) exp1.push_back(plan[i].o);
            else     exp0.push_back(plan[i].o);
        end
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #1;
            drive_op(plan[i].hold ? op : 6'($urandom));
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_random(input int n);
        logic [5:0] op;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 6))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: op = rand_illegal();
            endcase
            run_instr(op, -1);
        end
    endtask

    // Monitor: every cycle the selected instance presents outputs, compare against the scoreboard.
    always @(negedge clk) begin
        ov_t a;
        ov_t e;
        if (mon_en) begin
            a = sel ? act1 : act0;
            if (rst) begin
                check("reset_outputs", a, '0);
            end else if (sel ? (exp1.size() == 0) : (exp0.size() == 0)) begin
                vectors++;
                miscompares++;
                $display("FAIL underflow (t=%0t): got %h with no expected cycle queued", $time, a);
            end else begin
                e = sel ? exp1.pop_front() : exp0.pop_front();
                check("cycle", a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.Opcode = 6'd0;
        bus1.Opcode = 6'd0;
        #1 rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();

        // MEM_WAIT = 0 instance
        run_instr(OP_LW, -1);
        run_instr(OP_SW, -1);
        run_instr(OP_R, -1);
        run_instr(OP_BEQ, -1);
        run_instr(OP_J, -1);
        run_instr(6'b111111, -1);
        run_instr(OP_ADDI, -1);
        run_random(25);
        @(negedge clk);
        #1 rst = 1'b1;
        sel = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();

        // MEM_WAIT = 2 instance
        run_instr(OP_SW, -1);
        run_instr(OP_LW, -1);
        run_instr(6'b111111, -1);
        run_instr(OP_ADDI, -1);
        // Abort a load in the middle of MRD: IF(3), ID, MADR, MRD cycle 0 are driven, then reset.
        run_instr(OP_LW, 6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset_mid_mrd", act1, '0);
        repeat (2) @(negedge clk);
        release_rst();
        run_instr(OP_LW, -1);
        run_random(25);

        @(negedge clk);
        #1 mon_en = 1'b0;
        vectors++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d/%0d queued cycles, expected 0/0", exp0.size(), exp1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
